// File: rtl/sha3_sponge_ctrl.sv
// Sponge sequencer for Keccak-f[1600]: absorbs 16-bit stream words into rate blocks
// with SHA3 padding, launches one permutation per block and squeezes the digest out.
`timescale 1ns/1ps
module sha3_sponge_ctrl #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [WIDTH-1:0]  TDATA_i,
  input  logic [1:0]        TKEEP_i,
  input  logic [1:0]        TUSER_i,
  input  logic              TLAST_i,
  input  logic              TVALID_i,
  output logic              TREADY_o,
  output logic              blk_we,
  output logic [ADDR_W-1:0] blk_addr,
  output logic [WIDTH-1:0]  blk_data,
  output logic              perm_start,
  output logic              perm_first,
  input  logic              perm_done,
  output logic [ADDR_W-1:0] dig_rd_addr,
  input  logic [WIDTH-1:0]  dig_rd_data,
  output logic [WIDTH-1:0]  TDATA_o,
  output logic              TVALID_o,
  output logic              TLAST_o,
  input  logic              TREADY_i,
  output logic              busy,
  output logic [1:0]        mode_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ABSORB, S_PAD, S_PERM, S_PERM_WAIT, S_SQUEEZE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic              last_q, last_d;
  logic              first_q, first_d;
  logic              pend_q, pend_d;
  logic              padblk_q, padblk_d;
  logic [ADDR_W-1:0] sq_addr_q, sq_addr_d;
  logic              sq_rd_q, sq_rd_d;
  logic              tvalid_q, tvalid_d;
  logic [WIDTH-1:0]  tdata_q, tdata_d;
  logic              tlast_q, tlast_d;

  logic [1:0]        mode_cur;
  logic [ADDR_W-1:0] rate_words, dig_words;
  logic              rate_last, rdy, acc, keep_full;
  logic [WIDTH-1:0]  tail_word, absorb_word, pad_word;

  // Mode is not latched yet while the first word is being accepted.
  assign mode_cur   = (state_q == S_IDLE) ? TUSER_i : mode_q;
  assign rate_words = (mode_cur == 2'd0) ? ADDR_W'(72) :
                      (mode_cur == 2'd1) ? ADDR_W'(68) :
                      (mode_cur == 2'd2) ? ADDR_W'(52) : ADDR_W'(36);
  assign dig_words  = (mode_q == 2'd0) ? ADDR_W'(14) :
                      (mode_q == 2'd1) ? ADDR_W'(16) :
                      (mode_q == 2'd2) ? ADDR_W'(24) : ADDR_W'(32);
  assign rate_last  = (cnt_q == rate_words - ADDR_W'(1));
  assign rdy        = ((state_q == S_IDLE) || (state_q == S_ABSORB)) && !ARESET;
  assign acc        = TVALID_i && rdy;
  assign keep_full  = TKEEP_i[1];

  // A full last word defers the 0x06 pad byte to the next block word.
  assign tail_word   = keep_full  ? TDATA_i :
                       TKEEP_i[0] ? {8'h06, TDATA_i[7:0]} : WIDTH'(16'h0006);
  assign absorb_word = !TLAST_i ? TDATA_i :
                       (tail_word | ((rate_last && !keep_full) ? WIDTH'(16'h8000) : '0));
  assign pad_word    = (pend_q ? WIDTH'(16'h0006) : '0) |
                       (rate_last ? WIDTH'(16'h8000) : '0);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mode_q    <= '0;
      last_q    <= 1'b0;
      first_q   <= 1'b0;
      pend_q    <= 1'b0;
      padblk_q  <= 1'b0;
      sq_addr_q <= '0;
      sq_rd_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      last_q    <= last_d;
      first_q   <= first_d;
      pend_q    <= pend_d;
      padblk_q  <= padblk_d;
      sq_addr_q <= sq_addr_d;
      sq_rd_q   <= sq_rd_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tlast_q   <= tlast_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    last_d    = last_q;
    first_d   = first_q;
    pend_d    = pend_q;
    padblk_d  = padblk_q;
    sq_addr_d = sq_addr_q;
    sq_rd_d   = sq_rd_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    unique case (state_q)
      S_IDLE, S_ABSORB: begin
        if (acc) begin
          if (state_q == S_IDLE) begin
            mode_d  = TUSER_i;
            first_d = 1'b1;
          end
          if (rate_last) begin
            state_d  = S_PERM;
            last_d   = TLAST_i && !keep_full;
            padblk_d = TLAST_i && keep_full;
          end else begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = TLAST_i ? S_PAD : S_ABSORB;
            pend_d  = TLAST_i && keep_full;
          end
        end
      end
      S_PAD: begin
        pend_d = 1'b0;
        if (rate_last) begin
          state_d = S_PERM;
          last_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      S_PERM: begin
        first_d = 1'b0;
        state_d = S_PERM_WAIT;
      end
      S_PERM_WAIT: begin
        if (perm_done) begin
          cnt_d = '0;
          if (last_q) begin
            state_d   = S_SQUEEZE;
            sq_addr_d = '0;
            sq_rd_d   = 1'b0;
            tvalid_d  = 1'b0;
          end else if (padblk_q) begin
            state_d  = S_PAD;
            pend_d   = 1'b1;
            padblk_d = 1'b0;
          end else begin
            state_d = S_ABSORB;
          end
        end
      end
      S_SQUEEZE: begin
        // One cycle to present the address, one to capture, then hold until taken.
        if (!tvalid_q && !sq_rd_q) sq_rd_d = 1'b1;
        if (sq_rd_q) begin
          tdata_d  = dig_rd_data;
          tlast_d  = (sq_addr_q == dig_words - ADDR_W'(1));
          tvalid_d = 1'b1;
          sq_rd_d  = 1'b0;
        end
        if (tvalid_q && TREADY_i) begin
          tvalid_d = 1'b0;
          if (tlast_q) begin
            state_d = S_IDLE;
            tlast_d = 1'b0;
          end else begin
            sq_addr_d = sq_addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    TREADY_o    = rdy;
    blk_we      = 1'b0;
    blk_addr    = cnt_q;
    blk_data    = '0;
    if (acc) begin
      blk_we   = 1'b1;
      blk_data = absorb_word;
    end else if (state_q == S_PAD) begin
      blk_we   = 1'b1;
      blk_data = pad_word;
    end
    perm_start  = (state_q == S_PERM);
    perm_first  = (state_q == S_PERM) && first_q;
    dig_rd_addr = (state_q == S_SQUEEZE) ? sq_addr_q : '0;
    TDATA_o     = tdata_q;
    TVALID_o    = tvalid_q;
    TLAST_o     = tlast_q;
    busy        = (state_q != S_IDLE);
    mode_o      = mode_q;
  end

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// Directed bench for sha3_sponge_ctrl with a behavioural permutation core and digest RAM.
`timescale 1ns/1ps
module tb_sha3_sponge_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] TDATA_i = '0;
  logic [1:0]  TKEEP_i = '0, TUSER_i = '0;
  logic        TLAST_i = 1'b0, TVALID_i = 1'b0;
  logic        TREADY_o, blk_we, perm_start, perm_first;
  logic [6:0]  blk_addr, dig_rd_addr;
  logic [15:0] blk_data, TDATA_o;
  logic        perm_done = 1'b0;
  logic [15:0] dig_rd_data = '0;
  logic        TVALID_o, TLAST_o, busy;
  logic        TREADY_i = 1'b1;
  logic [1:0]  mode_o;

  sha3_sponge_ctrl #(.WIDTH(16), .ADDR_W(7)) dut (
    .ACLK(clk), .ARESET(rst), .TDATA_i(TDATA_i), .TKEEP_i(TKEEP_i), .TUSER_i(TUSER_i),
    .TLAST_i(TLAST_i), .TVALID_i(TVALID_i), .TREADY_o(TREADY_o), .blk_we(blk_we),
    .blk_addr(blk_addr), .blk_data(blk_data), .perm_start(perm_start), .perm_first(perm_first),
    .perm_done(perm_done), .dig_rd_addr(dig_rd_addr), .dig_rd_data(dig_rd_data),
    .TDATA_o(TDATA_o), .TVALID_o(TVALID_o), .TLAST_o(TLAST_o), .TREADY_i(TREADY_i),
    .busy(busy), .mode_o(mode_o)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dig_f(input int unsigned a);
    return 16'h5A00 + 16'(a * 7);
  endfunction

  always @(posedge clk) dig_rd_data <= dig_f(int'(dig_rd_addr));

  logic [15:0] blk [128];
  logic        first_log [4];
  logic [15:0] outs [64];
  logic        outl [64];
  int          wr_cnt = 0, perm_cnt = 0, out_cnt = 0, cd = 0;
  logic        prev_we = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
  logic [15:0] prev_data = '0;
  logic        bp_en = 1'b0, clr_req = 1'b0;

  // Core model, block buffer capture and output monitor; inputs it drives change on negedge.
  always @(negedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 128; i++) blk[i] = 16'hDEAD;
      for (int i = 0; i < 4; i++) first_log[i] = 1'bx;
      wr_cnt = 0; perm_cnt = 0; out_cnt = 0;
    end
    if (rst) begin
      perm_done = 1'b0; cd = 0; TREADY_i = 1'b1;
      prev_we = 1'b0; prev_stall = 1'b0;
    end else begin
      perm_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) perm_done = 1'b1;
      end
      if (blk_we) begin
        blk[blk_addr] = blk_data;
        wr_cnt++;
      end
      if (perm_start) begin
        chk("perm_lat", 32'(prev_we), 1);
        if (perm_cnt < 4) first_log[perm_cnt] = perm_first;
        perm_cnt++;
        cd = 3;
      end
      prev_we = blk_we;
      TREADY_i = bp_en ? ~TREADY_i : 1'b1;
      if (prev_stall) begin
        chk("hold_valid", 32'(TVALID_o), 1);
        chk("hold_data", 32'(TDATA_o), 32'(prev_data));
        chk("hold_last", 32'(TLAST_o), 32'(prev_last));
      end
      if (TVALID_o && TREADY_i) begin
        if (out_cnt < 64) begin
          outs[out_cnt] = TDATA_o;
          outl[out_cnt] = TLAST_o;
        end
        out_cnt++;
      end
      prev_stall = TVALID_o && !TREADY_i;
      prev_data  = TDATA_o;
      prev_last  = TLAST_o;
    end
  end

  task automatic clear_log();
    clr_req = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    clr_req = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] k, input logic [1:0] u,
                      input logic l);
    bit ok = 1'b0;
    int i  = 0;
    TDATA_i = d; TKEEP_i = k; TUSER_i = u; TLAST_i = l; TVALID_i = 1'b1;
    while (!ok && i < 200) begin
      @(negedge clk);
      ok = TREADY_o;
      @(posedge clk); #1;
      i++;
    end
    TVALID_i = 1'b0; TLAST_i = 1'b0;
    chk("send_accept", 32'(ok), 1);
  endtask

  task automatic wait_idle();
    int i = 0;
    while (i < 4000 && (busy || out_cnt == 0)) begin
      @(negedge clk);
      i++;
    end
    chk("idle_reached", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input int n);
    int nl = 0;
    chk("out_count", 32'(out_cnt), 32'(n));
    for (int k = 0; k < n && k < 64; k++) begin
      chk("out_data", 32'(outs[k]), 32'(dig_f(k)));
      if (outl[k] === 1'b1) nl++;
    end
    chk("out_last_pos", 32'(outl[n-1]), 1);
    chk("out_last_cnt", 32'(nl), 1);
  endtask

  task automatic run_empty256();
    int nz = 0;
    clear_log();
    send(16'h0000, 2'b00, 2'd1, 1'b1);
    wait_idle();
    chk("e256_writes", 32'(wr_cnt), 68);
    chk("e256_w0", 32'(blk[0]), 32'h0006);
    for (int a = 1; a < 67; a++) if (blk[a] !== 16'h0000) nz++;
    chk("e256_mid_zero", 32'(nz), 0);
    chk("e256_w67", 32'(blk[67]), 32'h8000);
    chk("e256_perms", 32'(perm_cnt), 1);
    chk("e256_first", 32'(first_log[0]), 1);
    chk("e256_mode", 32'(mode_o), 1);
    check_out(16);
  endtask

  initial begin
    #2;
    chk("rst_tready", 32'(TREADY_o), 0);
    chk("rst_we", 32'(blk_we), 0);
    chk("rst_pstart", 32'(perm_start), 0);
    chk("rst_tvalid", 32'(TVALID_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mode", 32'(mode_o), 0);
    chk("rst_rdaddr", 32'(dig_rd_addr), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_empty256();

    // SHA3-224, single full last word: pad byte moves to word 1
    clear_log();
    send(16'h6261, 2'b11, 2'd0, 1'b1);
    wait_idle();
    chk("t224_writes", 32'(wr_cnt), 72);
    chk("t224_w0", 32'(blk[0]), 32'h6261);
    chk("t224_w1", 32'(blk[1]), 32'h0006);
    chk("t224_w2", 32'(blk[2]), 32'h0000);
    chk("t224_w71", 32'(blk[71]), 32'h8000);
    chk("t224_mode", 32'(mode_o), 0);
    check_out(14);

    // SHA3-224, exactly one rate block of data: extra pad-only block
    clear_log();
    for (int i = 0; i < 72; i++)
      send(16'h0100 + 16'(i), 2'b11, 2'd0, i == 71);
    wait_idle();
    chk("fb_writes", 32'(wr_cnt), 144);
    chk("fb_perms", 32'(perm_cnt), 2);
    chk("fb_first0", 32'(first_log[0]), 1);
    chk("fb_first1", 32'(first_log[1]), 0);
    chk("fb_w0", 32'(blk[0]), 32'h0006);
    chk("fb_w1", 32'(blk[1]), 32'h0000);
    chk("fb_w70", 32'(blk[70]), 32'h0000);
    chk("fb_w71", 32'(blk[71]), 32'h8000);
    check_out(14);

    // SHA3-512, 36 words with input gaps, later TUSER changes ignored, last byte-only word
    clear_log();
    for (int i = 0; i < 35; i++) begin
      send(16'h1000 + 16'(i), 2'b11, (i == 0) ? 2'd3 : 2'd0, 1'b0);
      if (i % 5 == 4) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    send(16'h12AB, 2'b01, 2'd1, 1'b1);
    wait_idle();
    chk("t512_writes", 32'(wr_cnt), 36);
    chk("t512_w0", 32'(blk[0]), 32'h1000);
    chk("t512_w34", 32'(blk[34]), 32'h1022);
    chk("t512_w35", 32'(blk[35]), 32'h86AB);
    chk("t512_perms", 32'(perm_cnt), 1);
    chk("t512_mode", 32'(mode_o), 3);
    check_out(32);

    // Output backpressure
    bp_en = 1'b1;
    run_empty256();
    bp_en = 1'b0;

    // Asynchronous reset while waiting on the permutation
    clear_log();
    send(16'h0000, 2'b00, 2'd1, 1'b1);
    for (int i = 0; i < 200 && perm_cnt == 0; i++) @(posedge clk);
    chk("ar_perm_seen", 32'(perm_cnt), 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("ar_tready", 32'(TREADY_o), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_pstart", 32'(perm_start), 0);
    chk("ar_we", 32'(blk_we), 0);
    chk("ar_tvalid", 32'(TVALID_o), 0);
    chk("ar_mode", 32'(mode_o), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    run_empty256();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
